// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
// Holds the default bus widths, FSM states, requester ids and the counter helper.
package mem_arb_pkg;

    localparam int ADDR_WIDTH_DEF = 20;
    localparam int DATA_WIDTH_DEF = 16;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DMA = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_ACK
    } state_t;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin winner select.
// The last-grant register is updated once the granted transaction is acknowledged.
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       update,
    input  logic       update_idx,
    output logic       winner
);

    logic last;

    // Under contention the requester not served last wins; otherwise the
    // lone requester wins. With no request the output is a don't-care.
    assign winner = (req == 2'b11) ? ~last : req[1];

    always_ff @(posedge clk) begin
        if (!reset)
            last <= REQ_DMA;
        else if (update)
            last <= update_idx;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a CPU and a loader/DMA requester onto one single-port data memory.
// A transaction is latched in IDLE and replayed as IDLE -> ISSUE -> (WAIT) -> ACK.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            req,
    input  logic [1:0]            we,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic [1:0]            ack,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  busy,
    output logic [15:0]           rd_count,
    output logic [15:0]           wr_count
);

    state_t                state, state_nxt;
    logic                  win, win_q, we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  grant_en;

    assign grant_en = (state == ST_IDLE) && (|req);

    rr_arbiter2 u_arb (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .update     (state == ST_ACK),
        .update_idx (win_q),
        .winner     (win)
    );

    always_comb begin
        state_nxt = state;
        ack       = 2'b00;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        busy      = (state != ST_IDLE);
        case (state)
            ST_IDLE:  if (|req) state_nxt = ST_ISSUE;
            ST_ISSUE: begin
                mem_write = we_q;
                mem_read  = ~we_q;
                state_nxt = we_q ? ST_ACK : ST_WAIT;
            end
            ST_WAIT:  state_nxt = ST_ACK;
            ST_ACK: begin
                ack[win_q] = 1'b1;
                state_nxt  = ST_IDLE;
            end
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Latched request is the only source for the memory bus, so later input
    // changes cannot disturb a transaction in flight.
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= ST_IDLE;
            win_q    <= REQ_CPU;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0   <= '0;
            rdata1   <= '0;
            rd_count <= '0;
            wr_count <= '0;
        end else begin
            state <= state_nxt;
            if (grant_en) begin
                win_q   <= win;
                we_q    <= we[win];
                addr_q  <= win ? addr1 : addr0;
                wdata_q <= win ? wdata1 : wdata0;
            end
            if (state == ST_WAIT) begin
                if (win_q) rdata1 <= mem_rdata;
                else       rdata0 <= mem_rdata;
            end
            if (state == ST_ACK) begin
                if (we_q) wr_count <= sat_inc(wr_count);
                else      rd_count <= sat_inc(rd_count);
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a transaction table plus hand-written
// sequences for drop/change, reset in WAIT, continuous contention and saturation.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req, we;
    logic [19:0] addr0, addr1;
    logic [15:0] wdata0, wdata1;
    logic [1:0]  ack;
    logic [15:0] rdata0, rdata1;
    logic [19:0] mem_addr;
    logic [15:0] mem_wdata, mem_rdata;
    logic        mem_read, mem_write, busy;
    logic [15:0] rd_count, wr_count;

    int total = 0;
    int bad   = 0;

    logic [15:0] mem [0:255];

    mem_arbiter #(.ADDR_WIDTH(20), .DATA_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack(ack), .rdata0(rdata0), .rdata1(rdata1),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .busy(busy),
        .rd_count(rd_count), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    // Synchronous memory model: read data appears the cycle after mem_read.
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0;
        mem_rdata = 16'h0;
    end
    always @(posedge clk) begin
        if (mem_write) mem[mem_addr[7:0]] <= mem_wdata;
        if (mem_read)  mem_rdata <= mem[mem_addr[7:0]];
    end

    always @(negedge clk) begin
        total++;
        if (mem_read && mem_write) begin
            bad++;
            $display("FAIL strobe_excl: mem_read=%0b mem_write=%0b both high", mem_read, mem_write);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  req;
        logic [1:0]  we;
        logic [19:0] a0;
        logic [19:0] a1;
        logic [15:0] d0;
        logic [15:0] d1;
        logic [1:0]  exp_ack;
        int          lat;
        logic [19:0] exp_maddr;
        logic [15:0] exp_rdata;
        logic [15:0] exp_wr;
        logic [15:0] exp_rd;
    } vec_t;

    vec_t vt [7];

    task automatic run_vec(input vec_t v, input int idx);
        int n;
        req = v.req; we = v.we; addr0 = v.a0; addr1 = v.a1; wdata0 = v.d0; wdata1 = v.d1;
        tick();
        n = 1;
        check($sformatf("v%0d_mem_write", idx), mem_write, (v.lat == 2));
        check($sformatf("v%0d_mem_read", idx), mem_read, (v.lat == 3));
        check($sformatf("v%0d_mem_addr", idx), mem_addr, v.exp_maddr);
        while (ack == 2'b00 && n < 8) begin
            tick();
            n++;
        end
        check($sformatf("v%0d_ack", idx), ack, v.exp_ack);
        check($sformatf("v%0d_lat", idx), n, v.lat);
        if (v.lat == 3)
            check($sformatf("v%0d_rdata", idx), v.exp_ack[1] ? rdata1 : rdata0, v.exp_rdata);
        req = 2'b00;
        tick();
        check($sformatf("v%0d_ack_pulse", idx), ack, 2'b00);
        check($sformatf("v%0d_wr_count", idx), wr_count, v.exp_wr);
        check($sformatf("v%0d_rd_count", idx), rd_count, v.exp_rd);
    endtask

    initial begin
        vec_t v;
        int   nack, last_c, n;

        //        req    we     a0        a1        d0        d1        ack   lat maddr     rdata     wr     rd
        vt[0] = '{2'b01, 2'b01, 20'h00010, 20'h00000, 16'hBEEF, 16'h0000, 2'b01, 2, 20'h00010, 16'h0000, 16'd1, 16'd0};
        vt[1] = '{2'b10, 2'b00, 20'h00000, 20'h00010, 16'h0000, 16'h0000, 2'b10, 3, 20'h00010, 16'hBEEF, 16'd1, 16'd1};
        vt[2] = '{2'b11, 2'b11, 20'h00020, 20'h00030, 16'h1111, 16'h2222, 2'b01, 2, 20'h00020, 16'h0000, 16'd2, 16'd1};
        vt[3] = '{2'b11, 2'b11, 20'h00020, 20'h00030, 16'h1111, 16'h2222, 2'b10, 2, 20'h00030, 16'h0000, 16'd3, 16'd1};
        vt[4] = '{2'b01, 2'b00, 20'h00030, 20'h00000, 16'h0000, 16'h0000, 2'b01, 3, 20'h00030, 16'h2222, 16'd3, 16'd2};
        vt[5] = '{2'b10, 2'b00, 20'h00000, 20'h00020, 16'h0000, 16'h0000, 2'b10, 3, 20'h00020, 16'h1111, 16'd3, 16'd3};
        vt[6] = '{2'b11, 2'b00, 20'h00010, 20'h00030, 16'h0000, 16'h0000, 2'b01, 3, 20'h00010, 16'hBEEF, 16'd3, 16'd4};

        reset = 1'b0; req = 2'b00; we = 2'b00;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        tick(); tick();
        check("rst_ack", ack, 2'b00);
        check("rst_strobes", {mem_read, mem_write}, 2'b00);
        check("rst_mem_addr", mem_addr, 20'h0);
        check("rst_mem_wdata", mem_wdata, 16'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_rdata", {rdata0, rdata1}, 32'h0);
        check("rst_counts", {wr_count, rd_count}, 32'h0);
        reset = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) run_vec(vt[i], i);

        // Drop req and scramble inputs while the write is in flight.
        req = 2'b01; we = 2'b01; addr0 = 20'h00050; wdata0 = 16'h5555;
        tick();
        check("drop_mem_write", mem_write, 1'b1);
        check("drop_mem_addr", mem_addr, 20'h00050);
        req = 2'b00; we = 2'b00; addr0 = 20'h00060; wdata0 = 16'h6666;
        tick();
        check("drop_ack", ack, 2'b01);
        check("drop_addr_held", mem_addr, 20'h00050);
        check("drop_wdata_held", mem_wdata, 16'h5555);
        tick();
        check("drop_wr_count", wr_count, 16'd4);
        v = '{2'b01, 2'b00, 20'h00050, 20'h00000, 16'h0000, 16'h0000, 2'b01, 3, 20'h00050, 16'h5555, 16'd4, 16'd5};
        run_vec(v, 7);

        // Reset while a read sits in WAIT.
        req = 2'b10; we = 2'b00; addr1 = 20'h00010;
        tick();
        check("rw_mem_read", mem_read, 1'b1);
        tick();
        reset = 1'b0;
        tick();
        check("rw_ack", ack, 2'b00);
        check("rw_strobes", {mem_read, mem_write}, 2'b00);
        check("rw_busy", busy, 1'b0);
        check("rw_counts", {wr_count, rd_count}, 32'h0);
        check("rw_rdata1", rdata1, 16'h0);
        check("rw_mem_addr", mem_addr, 20'h0);
        reset = 1'b1;

        // Continuous contention: grants alternate starting with requester 0.
        req = 2'b11; we = 2'b00; addr0 = 20'h00010; addr1 = 20'h00030;
        nack = 0; last_c = 0;
        for (int c = 1; c <= 40 && nack < 4; c++) begin
            tick();
            if (ack != 2'b00) begin
                check($sformatf("cont_order%0d", nack), ack, (nack % 2) ? 2'b10 : 2'b01);
                check($sformatf("cont_rdata%0d", nack), (nack % 2) ? rdata1 : rdata0,
                      (nack % 2) ? 16'h2222 : 16'hBEEF);
                if (nack == 0) check("cont_first_lat", c, 3);
                else           check($sformatf("cont_spacing%0d", nack), c - last_c, 4);
                last_c = c;
                nack++;
            end
        end
        check("cont_acks", nack, 4);
        req = 2'b00;
        for (int i = 0; i < 10 && busy; i++) tick();
        check("cont_idle", busy, 1'b0);
        check("cont_rd_count", rd_count, 16'd4);

        // Saturation of the write counter.
        force dut.wr_count = 16'hFFFE;
        tick();
        release dut.wr_count;
        tick();
        check("sat_preload", wr_count, 16'hFFFE);
        for (int k = 0; k < 3; k++) begin
            req = 2'b01; we = 2'b01; addr0 = 20'h00070 + 20'(k); wdata0 = 16'(k);
            n = 0;
            do begin
                tick();
                n++;
            end while (ack == 2'b00 && n < 8);
            check($sformatf("sat_ack%0d", k), ack, 2'b01);
            req = 2'b00;
            tick();
            check($sformatf("sat_wr_count%0d", k), wr_count, 16'hFFFF);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
